// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle CPU control path: sequencer state
// codes, opcode/funct constants, trap causes and the legal-instruction check.
// The instruction-parse control LUT imports this same package, so the state
// codes here are the ones it indexes on.
package cpu_defs_pkg;

   // Sequencer state codes as seen by the control LUT
   typedef enum logic [2:0] {
      ST_ID   = 3'd0,
      ST_IF   = 3'd1,
      ST_EXEC = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4,
      ST_HALT = 3'd5
   } state_e;

   // Reason the sequencer parked itself in HALT
   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_ILLEGAL = 2'd1,
      CAUSE_TIMEOUT = 2'd2
   } cause_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   // True for every opcode/funct pair the datapath can execute past ID
   function automatic logic isLegal(input logic [5:0] op, input logic [5:0] fn);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_LW, OP_SW, OP_ADDI, OP_XORI, OP_JAL, OP_BEQ, OP_BNE, OP_J: ok = 1'b1;
         OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT) || (fn == FN_JR);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/multicycle_state_sequencer_if.sv
// Bundle between the sequencer and the rest of the datapath: instruction
// fields in, memory handshake and control/status out.
interface multicycle_state_sequencer_if #(parameter int CNT_W = 32);

   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             mem_ready;
   logic [2:0]       state;
   logic             mem_req;
   logic             mem_we;
   logic             ir_load;
   logic             retire;
   logic             trap;
   logic [1:0]       trap_cause;
   logic [CNT_W-1:0] instr_count;
   logic [CNT_W-1:0] cycle_count;

   // The sequencer side drives the handshake and status
   modport master (
      input  opcode, funct, mem_ready,
      output state, mem_req, mem_we, ir_load, retire, trap, trap_cause,
             instr_count, cycle_count
   );

   // The datapath/memory side supplies the instruction fields and ready
   modport slave (
      output opcode, funct, mem_ready,
      input  state, mem_req, mem_we, ir_load, retire, trap, trap_cause,
             instr_count, cycle_count
   );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear wins over
// increment so a state change always restarts it from zero.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   logic [W-1:0] count_q;

   // Count register: clear first, then saturating increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + W'(1);
      end
   end

   assign q = count_q;

endmodule

// File: rtl/multicycle_state_sequencer.sv
// Sequencer FSM for the multi-cycle CPU: walks each instruction through
// IF/ID/EXEC/MEM/WB, handshakes with unified memory, counts retired
// instructions and cycles, and traps into a sticky HALT on an illegal
// instruction or a memory request that never completes.
module multicycle_state_sequencer
   import cpu_defs_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 16
) (
   input logic                          clk,
   input logic                          reset,
   multicycle_state_sequencer_if.master bus
);

   localparam int              TO_W         = 8;
   localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   cause_e           trapCause_q, trapCause_d;
   logic             memReq, memWe, irLoad, retire;
   logic             timeoutHit, isJr, goesToWb;
   logic [TO_W-1:0]  timeoutCnt;
   logic [CNT_W-1:0] instrCount, cycleCount;

   // A stalled request traps on the cycle the wait count would reach TIMEOUT;
   // the ready check is ahead of this in the FSM so a late ready still wins.
   assign timeoutHit = (timeoutCnt == TIMEOUT_LAST);
   assign isJr       = (bus.opcode == OP_RTYPE) && (bus.funct == FN_JR);
   assign goesToWb   = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_ADDI) ||
                       (bus.opcode == OP_XORI);

   // State and trap-cause registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IF;
         trapCause_q <= CAUSE_NONE;
      end else begin
         state_q     <= state_d;
         trapCause_q <= trapCause_d;
      end
   end

   // Next-state decode plus memory request and the two combinational strobes
   always_comb begin
      state_d     = state_q;
      trapCause_d = trapCause_q;
      memReq      = 1'b0;
      memWe       = 1'b0;
      irLoad      = 1'b0;
      retire      = 1'b0;
      case (state_q)
         ST_IF: begin
            memReq = 1'b1;
            if (bus.mem_ready) begin
               irLoad  = 1'b1;
               state_d = ST_ID;
            end else if (timeoutHit) begin
               state_d     = ST_HALT;
               trapCause_d = CAUSE_TIMEOUT;
            end
         end
         ST_ID: begin
            if (bus.opcode == OP_J) begin
               retire  = 1'b1;
               state_d = ST_IF;
            end else if (isLegal(bus.opcode, bus.funct)) begin
               state_d = ST_EXEC;
            end else begin
               state_d     = ST_HALT;
               trapCause_d = CAUSE_ILLEGAL;
            end
         end
         ST_EXEC: begin
            if (isJr) begin
               retire  = 1'b1;
               state_d = ST_IF;
            end else if (goesToWb) begin
               state_d = ST_WB;
            end else begin
               state_d = ST_MEM;
            end
         end
         ST_MEM: begin
            case (bus.opcode)
               OP_LW: begin
                  memReq = 1'b1;
                  if (bus.mem_ready) begin
                     state_d = ST_WB;
                  end else if (timeoutHit) begin
                     state_d     = ST_HALT;
                     trapCause_d = CAUSE_TIMEOUT;
                  end
               end
               OP_SW: begin
                  memReq = 1'b1;
                  memWe  = 1'b1;
                  if (bus.mem_ready) begin
                     retire  = 1'b1;
                     state_d = ST_IF;
                  end else if (timeoutHit) begin
                     state_d     = ST_HALT;
                     trapCause_d = CAUSE_TIMEOUT;
                  end
               end
               OP_JAL: begin
                  retire  = 1'b1;
                  state_d = ST_IF;
               end
               default: state_d = ST_WB;
            endcase
         end
         ST_WB: begin
            retire  = 1'b1;
            state_d = ST_IF;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IF;
      endcase
   end

   // Wait counter for the current state's memory request
   sat_counter #(.W(TO_W)) uTimeoutCnt (
      .clk   (clk),
      .reset (reset),
      .inc   (memReq & ~bus.mem_ready),
      .clr   (state_d != state_q),
      .q     (timeoutCnt)
   );

   // Retired-instruction counter
   sat_counter #(.W(CNT_W)) uInstrCnt (
      .clk   (clk),
      .reset (reset),
      .inc   (retire),
      .clr   (1'b0),
      .q     (instrCount)
   );

   // Cycle counter, frozen once the sequencer has halted
   sat_counter #(.W(CNT_W)) uCycleCnt (
      .clk   (clk),
      .reset (reset),
      .inc   (state_q != ST_HALT),
      .clr   (1'b0),
      .q     (cycleCount)
   );

   // IF drives a request as a Moore output, so the strobes and request are
   // masked while reset is held to keep the bus quiet during reset.
   assign bus.state       = state_q;
   assign bus.mem_req     = memReq & ~reset;
   assign bus.mem_we      = memWe & ~reset;
   assign bus.ir_load     = irLoad & ~reset;
   assign bus.retire      = retire & ~reset;
   assign bus.trap        = (state_q == ST_HALT);
   assign bus.trap_cause  = trapCause_q;
   assign bus.instr_count = instrCount;
   assign bus.cycle_count = cycleCount;

endmodule

// File: tb/tb_multicycle_state_sequencer.sv
// Directed bench for the sequencer: a table of instructions run back to back
// against a zero-wait memory, then hand-written sequences for delayed memory,
// illegal-instruction trap, timeout trap, mid-instruction reset and counter
// saturation. A second instance (CNT_W=3, TIMEOUT=4) runs in lockstep.
module tb_multicycle_state_sequencer;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       memReady;

   int compared;
   int mismatched;

   multicycle_state_sequencer_if #(.CNT_W(32)) busA ();
   multicycle_state_sequencer_if #(.CNT_W(3))  busS ();

   assign busA.opcode    = opcode;
   assign busA.funct     = funct;
   assign busA.mem_ready = memReady;
   assign busS.opcode    = opcode;
   assign busS.funct     = funct;
   assign busS.mem_ready = memReady;

   multicycle_state_sequencer #(.CNT_W(32), .TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (busA)
   );

   multicycle_state_sequencer #(.CNT_W(3), .TIMEOUT(4)) dutS (
      .clk   (clk),
      .reset (reset),
      .bus   (busS)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a sequence never completes
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      int          lat;
      logic [14:0] seq;
      int          reqCyc;
      int          weCyc;
   } vec_t;

   vec_t vecs[12];

   // One comparison with a FAIL line on mismatch
   task automatic checkOutput(input string name, input longint act, input longint exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Pulse reset across two rising edges, releasing it on a falling edge
   task automatic doReset();
      reset    = 1'b1;
      memReady = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Run one instruction on the main instance from IF until its retire strobe
   // (or HALT). Memory answers at once in IF and after memDelay wait cycles
   // in MEM. Called and returns on a falling edge.
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input int memDelay,
                                output int lat, output logic [14:0] seq, output int reqCyc,
                                output int weCyc, output int irlCnt, output int retCnt,
                                output logic halted);
      int   memSeen;
      logic sawRetire;
      lat = 0; seq = '0; reqCyc = 0; weCyc = 0; irlCnt = 0; retCnt = 0;
      halted = 1'b0; memSeen = 0;
      opcode = op;
      funct  = fn;
      for (int c = 0; c < 40; c++) begin
         if (busA.state == 3'd5) begin
            halted = 1'b1;
            break;
         end
         if (busA.state == 3'd3) begin
            memReady = (memSeen >= memDelay);
            memSeen++;
         end else begin
            memReady = 1'b1;
         end
         #1;
         if (lat < 5) seq[3*lat +: 3] = busA.state;
         lat++;
         reqCyc += int'(busA.mem_req);
         weCyc  += int'(busA.mem_we);
         irlCnt += int'(busA.ir_load);
         retCnt += int'(busA.retire);
         sawRetire = busA.retire;
         @(negedge clk);
         if (sawRetire) break;
      end
   endtask

   initial begin
      int          lat, reqCyc, weCyc, irlCnt, retCnt, reqCnt, strobes;
      logic [14:0] seq;
      logic        halted;
      longint      expCycles;

      compared   = 0;
      mismatched = 0;
      opcode     = 6'b000000;
      funct      = 6'b000000;

      //           op         fn         lat seq (s4..s0)                       req we
      vecs[0]  = '{6'b100011, 6'b000111, 5, {3'd4, 3'd3, 3'd2, 3'd0, 3'd1}, 2, 0}; // LW
      vecs[1]  = '{6'b101011, 6'b000111, 4, {3'd0, 3'd3, 3'd2, 3'd0, 3'd1}, 2, 1}; // SW
      vecs[2]  = '{6'b000010, 6'b000111, 2, {3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, 1, 0}; // J
      vecs[3]  = '{6'b000011, 6'b000111, 4, {3'd0, 3'd3, 3'd2, 3'd0, 3'd1}, 1, 0}; // JAL
      vecs[4]  = '{6'b000100, 6'b000111, 5, {3'd4, 3'd3, 3'd2, 3'd0, 3'd1}, 1, 0}; // BEQ
      vecs[5]  = '{6'b000101, 6'b000111, 5, {3'd4, 3'd3, 3'd2, 3'd0, 3'd1}, 1, 0}; // BNE
      vecs[6]  = '{6'b001000, 6'b000111, 4, {3'd0, 3'd4, 3'd2, 3'd0, 3'd1}, 1, 0}; // ADDI
      vecs[7]  = '{6'b001110, 6'b000111, 4, {3'd0, 3'd4, 3'd2, 3'd0, 3'd1}, 1, 0}; // XORI
      vecs[8]  = '{6'b000000, 6'b100000, 4, {3'd0, 3'd4, 3'd2, 3'd0, 3'd1}, 1, 0}; // ADD
      vecs[9]  = '{6'b000000, 6'b100010, 4, {3'd0, 3'd4, 3'd2, 3'd0, 3'd1}, 1, 0}; // SUB
      vecs[10] = '{6'b000000, 6'b101010, 4, {3'd0, 3'd4, 3'd2, 3'd0, 3'd1}, 1, 0}; // SLT
      vecs[11] = '{6'b000000, 6'b001000, 3, {3'd0, 3'd0, 3'd2, 3'd0, 3'd1}, 1, 0}; // JR

      // Reset state
      reset    = 1'b1;
      memReady = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("reset state", busA.state, 1);
      checkOutput("reset mem_req", busA.mem_req, 0);
      checkOutput("reset trap", busA.trap, 0);
      checkOutput("reset trap_cause", busA.trap_cause, 0);
      checkOutput("reset instr_count", busA.instr_count, 0);
      checkOutput("reset cycle_count", busA.cycle_count, 0);
      doReset();

      // Table: every legal instruction back to back with zero-wait memory
      expCycles = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].op, vecs[i].fn, 0, lat, seq, reqCyc, weCyc, irlCnt, retCnt, halted);
         expCycles += longint'(vecs[i].lat);
         $display("[TB] vector %0d opcode %b funct %b latency %0d", i, vecs[i].op, vecs[i].fn, lat);
         checkOutput("vec latency", lat, vecs[i].lat);
         checkOutput("vec state seq", seq, vecs[i].seq);
         checkOutput("vec mem_req cycles", reqCyc, vecs[i].reqCyc);
         checkOutput("vec mem_we cycles", weCyc, vecs[i].weCyc);
         checkOutput("vec ir_load count", irlCnt, 1);
         checkOutput("vec retire count", retCnt, 1);
         checkOutput("vec instr_count", busA.instr_count, i + 1);
         checkOutput("vec cycle_count", busA.cycle_count, expCycles);
      end

      // SW with three wait cycles in MEM
      applyStimulus(6'b101011, 6'b000000, 3, lat, seq, reqCyc, weCyc, irlCnt, retCnt, halted);
      expCycles += 7;
      checkOutput("sw wait latency", lat, 7);
      checkOutput("sw wait mem_req cycles", reqCyc, 5);
      checkOutput("sw wait mem_we cycles", weCyc, 4);
      checkOutput("sw wait retire count", retCnt, 1);
      checkOutput("sw wait instr_count", busA.instr_count, 13);
      checkOutput("sw wait cycle_count", busA.cycle_count, expCycles);

      // Illegal R-type funct traps straight after ID and stays halted
      applyStimulus(6'b000000, 6'b000111, 0, lat, seq, reqCyc, weCyc, irlCnt, retCnt, halted);
      expCycles += 2;
      checkOutput("illegal halted", halted, 1);
      checkOutput("illegal latency", lat, 2);
      checkOutput("illegal state", busA.state, 5);
      checkOutput("illegal trap", busA.trap, 1);
      checkOutput("illegal trap_cause", busA.trap_cause, 1);
      strobes = 0;
      for (int c = 0; c < 10; c++) begin
         memReady = c[0];
         #1;
         strobes += int'(busA.mem_req) + int'(busA.mem_we) + int'(busA.ir_load) + int'(busA.retire);
         @(negedge clk);
      end
      checkOutput("halt strobes", strobes, 0);
      checkOutput("halt state held", busA.state, 5);
      checkOutput("halt trap_cause held", busA.trap_cause, 1);
      checkOutput("halt instr_count frozen", busA.instr_count, 13);
      checkOutput("halt cycle_count frozen", busA.cycle_count, expCycles);

      // Timeout in IF: small instance traps after 4 request cycles, main keeps waiting
      doReset();
      opcode   = 6'b100011;
      memReady = 1'b0;
      reqCnt   = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         reqCnt += int'(busS.mem_req);
         @(negedge clk);
      end
      checkOutput("timeout req cycles", reqCnt, 4);
      checkOutput("timeout state", busS.state, 5);
      checkOutput("timeout trap", busS.trap, 1);
      checkOutput("timeout trap_cause", busS.trap_cause, 2);
      checkOutput("timeout mem_req dropped", busS.mem_req, 0);
      checkOutput("timeout cycle_count", busS.cycle_count, 4);
      checkOutput("timeout main still IF", busA.state, 1);
      reqCnt = 8;
      for (int c = 0; c < 12; c++) begin
         #1;
         reqCnt += int'(busA.mem_req);
         @(negedge clk);
      end
      checkOutput("timeout16 req cycles", reqCnt, 16);
      checkOutput("timeout16 state", busA.state, 5);
      checkOutput("timeout16 trap_cause", busA.trap_cause, 2);

      // Ready on the fourth request cycle beats the timeout
      doReset();
      for (int c = 0; c < 4; c++) begin
         memReady = (c == 3);
         #1;
         @(negedge clk);
      end
      checkOutput("late ready state", busS.state, 0);
      checkOutput("late ready trap", busS.trap, 0);
      checkOutput("late ready trap_cause", busS.trap_cause, 0);

      // Asynchronous reset in the middle of an LW's MEM state
      doReset();
      opcode   = 6'b100011;
      memReady = 1'b1;
      repeat (3) @(negedge clk);
      memReady = 1'b0;
      #1;
      checkOutput("mid mem state", busA.state, 3);
      checkOutput("mid mem mem_req", busA.mem_req, 1);
      checkOutput("mid mem cycle_count", busA.cycle_count, 3);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async reset state", busA.state, 1);
      checkOutput("async reset mem_req", busA.mem_req, 0);
      checkOutput("async reset mem_we", busA.mem_we, 0);
      checkOutput("async reset ir_load", busA.ir_load, 0);
      checkOutput("async reset retire", busA.retire, 0);
      checkOutput("async reset cycle_count", busA.cycle_count, 0);
      checkOutput("async reset instr_count", busA.instr_count, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(6'b100011, 6'b000000, 0, lat, seq, reqCyc, weCyc, irlCnt, retCnt, halted);
      checkOutput("restart lw latency", lat, 5);
      checkOutput("restart lw instr_count", busA.instr_count, 1);
      checkOutput("restart lw cycle_count", busA.cycle_count, 5);

      // Nine J instructions: 3-bit counters stick at 7, wide ones keep going
      doReset();
      for (int i = 0; i < 9; i++) begin
         applyStimulus(6'b000010, 6'b000000, 0, lat, seq, reqCyc, weCyc, irlCnt, retCnt, halted);
         if (i == 2) begin
            checkOutput("sat3 instr_count", busS.instr_count, 3);
            checkOutput("sat3 cycle_count", busS.cycle_count, 6);
         end
      end
      checkOutput("sat instr_count", busS.instr_count, 7);
      checkOutput("sat cycle_count", busS.cycle_count, 7);
      checkOutput("wide instr_count", busA.instr_count, 9);
      checkOutput("wide cycle_count", busA.cycle_count, 18);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
